// File: rtl/handshake_constant_arbiter_pkg.sv
// Shared sizing helpers for the constant-producing round-robin arbiter.
// Also used by the other shared-resource arbiters for ID width derivation.
package handshake_constant_arbiter_pkg;

    localparam int GRANT_CNT_WIDTH = 16;

    function automatic int clog2_int(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Requester IDs are at least one bit wide, even for a single requester.
    function automatic int id_bits(input int n);
        int w;
        w = clog2_int(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/handshake_constant_arbiter_if.sv
// Control-in / constant-out handshake bundle for handshake_constant_arbiter.
// The slave modport is the arbiter side, master is the environment side.
interface handshake_constant_arbiter_if
    import handshake_constant_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int ID_WIDTH = id_bits(NUM_REQ);

    logic [NUM_REQ-1:0]    ctrl_valid;
    logic [NUM_REQ-1:0]    ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic [ID_WIDTH-1:0]   outs_id;
    logic                  outs_valid;
    logic                  outs_ready;

    modport slave (
        input  ctrl_valid,
        output ctrl_ready,
        output outs,
        output outs_id,
        output outs_valid,
        input  outs_ready
    );

    modport master (
        output ctrl_valid,
        input  ctrl_ready,
        input  outs,
        input  outs_id,
        input  outs_valid,
        output outs_ready
    );
endinterface

// File: rtl/handshake_constant_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns one-hot grant, its encoded index and an any-request flag.
module rr_priority_picker
    import handshake_constant_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any_valid
);
    int j;

    // Scan farthest-first so the nearest request to ptr is written last.
    always_comb begin
        gnt       = '0;
        idx       = '0;
        j         = 0;
        any_valid = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = ID_WIDTH'(j);
            end
        end
    end
endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter sharing one registered constant output among NUM_REQ
// control channels. Define HANDSHAKE_CONST_ARB_STATS_EN to add grant_count.
module handshake_constant_arbiter
    import handshake_constant_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter int                    NUM_REQ     = 4
) (
    input  logic clk,
    input  logic rst,
    handshake_constant_arbiter_if.slave bus
`ifdef HANDSHAKE_CONST_ARB_STATS_EN
    ,
    output logic [GRANT_CNT_WIDTH-1:0] grant_count
`endif
);
    localparam int ID_WIDTH = id_bits(NUM_REQ);

    logic                full;
    logic [ID_WIDTH-1:0] id_q;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] rr_next;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic                any_valid;
    logic                can_load;
    logic                grant;
    logic                drain;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_picker (
        .req      (bus.ctrl_valid),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .idx      (gnt_idx),
        .any_valid(any_valid)
    );

    assign can_load       = !full || bus.outs_ready;
    assign grant          = can_load && any_valid;
    assign drain          = full && bus.outs_ready;
    assign bus.ctrl_ready = grant ? gnt : '0;
    assign bus.outs       = CONST_VALUE;
    assign bus.outs_id    = id_q;
    assign bus.outs_valid = full;

    assign rr_next = (gnt_idx == ID_WIDTH'(NUM_REQ - 1))
                   ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (grant) begin
            full   <= 1'b1;
            id_q   <= gnt_idx;
            rr_ptr <= rr_next;
        end else if (drain) begin
            full   <= 1'b0;
        end
    end

`ifdef HANDSHAKE_CONST_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else if (grant) begin
            grant_count <= grant_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed scoreboard bench for handshake_constant_arbiter (NUM_REQ=4).
// Grant-counter checks are built in when HANDSHAKE_CONST_ARB_STATS_EN is set.
module tb_handshake_constant_arbiter;
    localparam int          N   = 4;
    localparam int          DW  = 32;
    localparam logic [31:0] CV  = 32'hCAFE_0042;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int   sb[$];
    logic m_full;
    int   m_ptr;
    int   m_cnt;

    handshake_constant_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

`ifdef HANDSHAKE_CONST_ARB_STATS_EN
    logic [15:0] grant_count;
`endif

    handshake_constant_arbiter #(
        .DATA_WIDTH (DW),
        .CONST_VALUE(CV),
        .NUM_REQ    (N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HANDSHAKE_CONST_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model.
    task automatic cycle(input logic [N-1:0] cv, input logic ordy);
        int       g;
        int       i;
        logic     can;
        logic [N-1:0] er;
        bus.ctrl_valid = cv;
        bus.outs_ready = ordy;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (g < 0 && cv[i]) g = i;
        end
        can = !m_full || ordy;
        er  = '0;
        if (can && g >= 0) er[g] = 1'b1;
        check("ctrl_ready", 64'(bus.ctrl_ready), 64'(er));
        check("outs_valid", 64'(bus.outs_valid), 64'(m_full));
        check("outs", 64'(bus.outs), 64'(CV));
        if (m_full) check("outs_id", 64'(bus.outs_id), 64'(sb[0]));
`ifdef HANDSHAKE_CONST_ARB_STATS_EN
        check("grant_count", 64'(grant_count), 64'(m_cnt % 65536));
`endif
        if (m_full && ordy) void'(sb.pop_front());
        if (can && g >= 0) begin
            sb.push_back(g);
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
            m_cnt++;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp2[5];
        int exp3[4];
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{2, 0, 2, 0};
        checks   = 0;
        failures = 0;
        model_reset();
        rst = 1'b1;
        bus.ctrl_valid = '0;
        bus.outs_ready = 1'b0;
        #12;
        check("rst_valid", 64'(bus.outs_valid), 64'd0);
        check("rst_id", 64'(bus.outs_id), 64'd0);
        check("rst_outs", 64'(bus.outs), 64'(CV));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: idle
        repeat (5) cycle(4'b0000, 1'b1);

        // 2: all requesting, full rate
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1);
            check("t2_seq", 64'(bus.outs_id), 64'(exp2[k]));
            check("t2_full", 64'(bus.outs_valid), 64'd1);
        end

        // 3: grant 0 from ptr 1, then 0101 alternates 2,0
        cycle(4'b0001, 1'b1);
        check("t3_g0", 64'(bus.outs_id), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0101, 1'b1);
            check("t3_seq", 64'(bus.outs_id), 64'(exp3[k]));
        end

        // 4: back-pressure then simultaneous drain and grant
        repeat (4) begin
            cycle(4'b0010, 1'b0);
            check("t4_hold_id", 64'(bus.outs_id), 64'd0);
        end
        cycle(4'b0010, 1'b1);
        check("t4_replace_v", 64'(bus.outs_valid), 64'd1);
        check("t4_replace_id", 64'(bus.outs_id), 64'd1);
        cycle(4'b0000, 1'b0);

        // 5: async reset while full, ptr=2
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_v", 64'(bus.outs_valid), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(4'b1111, 1'b1);
        check("t5_first_id", 64'(bus.outs_id), 64'd0);
        cycle(4'b0000, 1'b1);

`ifdef HANDSHAKE_CONST_ARB_STATS_EN
        // 6: counter wrap over 70000 grants
        #1;
        rst = 1'b1;
        bus.ctrl_valid = 4'b1111;
        bus.outs_ready = 1'b1;
        #1;
        check("t6_clr", 64'(grant_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("t6_wrap", 64'(grant_count), 64'd4464);
        bus.ctrl_valid = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
